// File: rtl/standoff_match_engine_if.sv
// rtl/standoff_match_engine_if.sv - control/status bundle of the standoff match engine
//
// Purpose : groups the match controls (mode, load, seed, player 1 choice) and
//           the match status (bullets, actions, countdown, scores, pulses).
// Modports: master drives the controls and observes the status (board logic,
//           bench); slave is the engine itself.
interface standoff_match_engine_if #(
  parameter int BW          = 2,
  parameter int SW          = 3,
  parameter int COUNT_STEPS = 7
);
  logic [1:0]             mode;
  logic                   load;
  logic [15:0]            seed;
  logic [2:0]             p1_choice;
  logic [BW-1:0]          p1_bullets;
  logic [BW-1:0]          p2_bullets;
  logic [2:0]             p1_act;
  logic [2:0]             p2_act;
  logic [COUNT_STEPS-1:0] countdown;
  logic [SW-1:0]          p1_score;
  logic [SW-1:0]          p2_score;
  logic                   round_valid;
  logic                   match_over;
  logic [1:0]             winner;

  modport master (
    output mode, load, seed, p1_choice,
    input  p1_bullets, p2_bullets, p1_act, p2_act, countdown,
           p1_score, p2_score, round_valid, match_over, winner
  );

  modport slave (
    input  mode, load, seed, p1_choice,
    output p1_bullets, p2_bullets, p1_act, p2_act, countdown,
           p1_score, p2_score, round_valid, match_over, winner
  );
endinterface

// File: rtl/standoff_match_engine.sv
// rtl/standoff_match_engine.sv - best-of standoff match between player 1 and an LFSR opponent
//
// Purpose : runs countdown -> resolve rounds, tracks bullets and scores for
//           both players and stops in DONE once a player reaches WIN_SCORE.
// Ports   : clk   - system clock
//           reset - asynchronous active-high reset
//           bus   - slave side of standoff_match_engine_if (controls in,
//                   match status out)
module standoff_match_engine #(
  parameter int MAX_BULLETS = 3,
  parameter int BW          = 2,
  parameter int COUNT_STEPS = 7,
  parameter int TICK_NORMAL = 50_000_000,
  parameter int TICK_DEMO   = 10_000_000,
  parameter int WIN_SCORE   = 3,
  parameter int SW          = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  standoff_match_engine_if.slave bus
);

  localparam logic [1:0] ST_COUNT   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [2:0] ACT_IDLE   = 3'b000;
  localparam logic [2:0] ACT_RELOAD = 3'b100;
  localparam logic [2:0] ACT_SHOOT  = 3'b010;
  localparam logic [2:0] ACT_SHIELD = 3'b001;

  localparam logic [1:0] MODE_PAUSE  = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_DEMO   = 2'b10;
  localparam logic [1:0] MODE_SIM    = 2'b11;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  localparam int TICK_MAX = (TICK_NORMAL > TICK_DEMO) ? TICK_NORMAL : TICK_DEMO;
  localparam int TW       = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam logic [TW-1:0] NORMAL_LAST = TW'(TICK_NORMAL - 1);
  localparam logic [TW-1:0] DEMO_LAST   = TW'(TICK_DEMO - 1);

  localparam logic [BW-1:0] BUL_MAX = BW'(MAX_BULLETS);
  localparam logic [SW-1:0] SC_WIN  = SW'(WIN_SCORE);

  logic [1:0]             state;
  logic [COUNT_STEPS-1:0] countdown;
  logic [TW-1:0]          tick_cnt;
  logic [1:0]             mode_q;
  logic [15:0]            lfsr;
  logic [BW-1:0]          p1_bul, p2_bul;
  logic [2:0]             p1_act_q, p2_act_q;
  logic [SW-1:0]          p1_sc, p2_sc;
  logic                   round_valid_q;
  logic [1:0]             winner_q;

  logic                   mode_changed;
  logic                   tick;
  logic                   p1_onehot;
  logic [2:0]             r1_act, r2_act;
  logic [BW-1:0]          r1_bul, r2_bul;
  logic [SW-1:0]          r1_sc, r2_sc;
  logic [15:0]            lfsr_next;

  function automatic logic [BW-1:0] bullets_after(input logic [BW-1:0] b,
                                                  input logic [2:0]    act);
    logic [BW-1:0] r;
    r = b;
    if (act == ACT_RELOAD && b != BUL_MAX) r = b + BW'(1);
    // Shooting is only ever resolved with at least one bullet loaded.
    if (act == ACT_SHOOT) r = b - BW'(1);
    return r;
  endfunction

  // A stale count from the previous mode must not fire a tick on the cycle
  // the mode switches; the counter is cleared on that same edge.
  assign mode_changed = (bus.mode != mode_q);
  assign tick = (bus.mode == MODE_SIM) ||
                (!mode_changed && bus.mode == MODE_NORMAL && tick_cnt == NORMAL_LAST) ||
                (!mode_changed && bus.mode == MODE_DEMO   && tick_cnt == DEMO_LAST);

  // Fibonacci LFSR, taps 16/14/13/11 (bit 15 is tap 16).
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign p1_onehot = (bus.p1_choice == ACT_RELOAD) ||
                     (bus.p1_choice == ACT_SHOOT)  ||
                     (bus.p1_choice == ACT_SHIELD);

  always_comb begin
    r1_act = ACT_IDLE;
    if (p1_onehot && !(bus.p1_choice == ACT_SHOOT && p1_bul == '0))
      r1_act = bus.p1_choice;

    // The opponent's move comes from the LFSR value held during RESOLVE,
    // before it shifts.
    case (lfsr[1:0])
      2'b01:   r2_act = (p2_bul == '0) ? ACT_RELOAD : ACT_SHOOT;
      2'b10:   r2_act = ACT_SHIELD;
      default: r2_act = ACT_RELOAD;
    endcase

    r1_bul = bullets_after(p1_bul, r1_act);
    r2_bul = bullets_after(p2_bul, r2_act);

    r1_sc = p1_sc;
    if (r1_act == ACT_SHOOT && (r2_act == ACT_RELOAD || r2_act == ACT_IDLE))
      r1_sc = p1_sc + SW'(1);
    r2_sc = p2_sc;
    if (r2_act == ACT_SHOOT && (r1_act == ACT_RELOAD || r1_act == ACT_IDLE))
      r2_sc = p2_sc + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_COUNT;
      countdown     <= '1;
      tick_cnt      <= '0;
      mode_q        <= MODE_PAUSE;
      lfsr          <= LFSR_DEFAULT;
      p1_bul        <= '0;
      p2_bul        <= '0;
      p1_act_q      <= ACT_IDLE;
      p2_act_q      <= ACT_IDLE;
      p1_sc         <= '0;
      p2_sc         <= '0;
      round_valid_q <= 1'b0;
      winner_q      <= 2'b00;
    end else begin
      mode_q        <= bus.mode;
      round_valid_q <= 1'b0;
      if (bus.load) begin
        lfsr      <= (bus.seed == 16'h0000) ? LFSR_DEFAULT : bus.seed;
        state     <= ST_COUNT;
        countdown <= '1;
        tick_cnt  <= '0;
        p1_bul    <= '0;
        p2_bul    <= '0;
        p1_act_q  <= ACT_IDLE;
        p2_act_q  <= ACT_IDLE;
        p1_sc     <= '0;
        p2_sc     <= '0;
        winner_q  <= 2'b00;
      end else begin
        case (state)
          ST_COUNT: begin
            if (mode_changed)
              tick_cnt <= '0;
            else if (bus.mode == MODE_NORMAL || bus.mode == MODE_DEMO)
              tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
              if (countdown != '0) countdown <= countdown >> 1;
              else                 state     <= ST_RESOLVE;
            end
          end
          ST_RESOLVE: begin
            if (mode_changed) tick_cnt <= '0;
            if (bus.mode != MODE_PAUSE) begin
              lfsr          <= lfsr_next;
              p1_bul        <= r1_bul;
              p2_bul        <= r2_bul;
              p1_act_q      <= r1_act;
              p2_act_q      <= r2_act;
              p1_sc         <= r1_sc;
              p2_sc         <= r2_sc;
              round_valid_q <= 1'b1;
              // Both players can never score in the same round (shoot vs
              // shoot gives no point), so the winner is unambiguous.
              if (r1_sc == SC_WIN) begin
                state    <= ST_DONE;
                winner_q <= 2'b01;
              end else if (r2_sc == SC_WIN) begin
                state    <= ST_DONE;
                winner_q <= 2'b10;
              end else begin
                state     <= ST_COUNT;
                countdown <= '1;
              end
            end
          end
          default: begin
            // DONE: everything holds until load or reset.
          end
        endcase
      end
    end
  end

  assign bus.p1_bullets  = p1_bul;
  assign bus.p2_bullets  = p2_bul;
  assign bus.p1_act      = p1_act_q;
  assign bus.p2_act      = p2_act_q;
  assign bus.countdown   = countdown;
  assign bus.p1_score    = p1_sc;
  assign bus.p2_score    = p2_sc;
  assign bus.round_valid = round_valid_q;
  assign bus.match_over  = (state == ST_DONE);
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_standoff_match_engine.sv
// tb/tb_standoff_match_engine.sv - self-checking bench for standoff_match_engine
module tb_standoff_match_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  standoff_match_engine_if #(.BW(2), .SW(3), .COUNT_STEPS(7)) bus ();

  standoff_match_engine #(
    .MAX_BULLETS(3), .BW(2), .COUNT_STEPS(7),
    .TICK_NORMAL(6), .TICK_DEMO(4), .WIN_SCORE(3), .SW(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state of the match as the rules describe it.
  logic [15:0] m_lfsr;
  int          m_b1, m_b2, m_s1, m_s2, m_win;
  logic [2:0]  m_a1, m_a2;
  bit          m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int  taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[14:0], fb};
  endfunction

  task automatic model_load(input logic [15:0] s);
    m_lfsr = (s == 16'h0000) ? 16'hACE1 : s;
    m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_a1 = 3'b000; m_a2 = 3'b000; m_done = 1'b0;
  endtask

  task automatic model_round(input logic [2:0] c);
    bit legal;
    legal = (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
    m_a1 = legal ? c : 3'b000;
    if (m_a1 == 3'b010 && m_b1 == 0) m_a1 = 3'b000;
    case (m_lfsr % 4)
      1:       m_a2 = (m_b2 == 0) ? 3'b100 : 3'b010;
      2:       m_a2 = 3'b001;
      default: m_a2 = 3'b100;
    endcase
    if (m_a1 == 3'b010 && (m_a2 == 3'b100 || m_a2 == 3'b000)) m_s1++;
    if (m_a2 == 3'b010 && (m_a1 == 3'b100 || m_a1 == 3'b000)) m_s2++;
    if (m_a1 == 3'b100) m_b1 = (m_b1 < 3) ? m_b1 + 1 : 3;
    if (m_a1 == 3'b010) m_b1--;
    if (m_a2 == 3'b100) m_b2 = (m_b2 < 3) ? m_b2 + 1 : 3;
    if (m_a2 == 3'b010) m_b2--;
    m_lfsr = lfsr_step(m_lfsr);
    if (m_s1 == 3)      begin m_done = 1'b1; m_win = 1; end
    else if (m_s2 == 3) begin m_done = 1'b1; m_win = 2; end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ":p1_bullets"}, bus.p1_bullets, m_b1);
    chk({tag, ":p2_bullets"}, bus.p2_bullets, m_b2);
    chk({tag, ":p1_act"},     bus.p1_act,     m_a1);
    chk({tag, ":p2_act"},     bus.p2_act,     m_a2);
    chk({tag, ":p1_score"},   bus.p1_score,   m_s1);
    chk({tag, ":p2_score"},   bus.p2_score,   m_s2);
    chk({tag, ":match_over"}, bus.match_over, m_done);
    chk({tag, ":winner"},     bus.winner,     m_win);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ":countdown"},   bus.countdown,   7'h7F);
    chk({tag, ":p1_bullets"},  bus.p1_bullets,  0);
    chk({tag, ":p2_bullets"},  bus.p2_bullets,  0);
    chk({tag, ":p1_act"},      bus.p1_act,      0);
    chk({tag, ":p2_act"},      bus.p2_act,      0);
    chk({tag, ":p1_score"},    bus.p1_score,    0);
    chk({tag, ":p2_score"},    bus.p2_score,    0);
    chk({tag, ":round_valid"}, bus.round_valid, 0);
    chk({tag, ":match_over"},  bus.match_over,  0);
    chk({tag, ":winner"},      bus.winner,      0);
  endtask

  // Counts falling edges until round_valid is seen (bounded).
  task automatic wait_round(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.round_valid) break;
    end
    if (!bus.round_valid) chk("round_timeout", bus.round_valid, 1);
  endtask

  task automatic play_round(input logic [2:0] c, input bit check_len, input string tag);
    int n;
    bus.p1_choice = c;
    wait_round(n);
    if (check_len) chk({tag, ":round_len"}, n, 9);
    model_round(c);
    compare_all(tag);
  endtask

  task automatic steps_until_change(output int n);
    logic [6:0] prev;
    prev = bus.countdown;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (bus.countdown != prev) break;
    end
    if (bus.countdown == prev) chk("step_timeout", bus.countdown, prev >> 1);
  endtask

  task automatic wait_countdown(input logic [6:0] v);
    int n = 0;
    while (bus.countdown != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_countdown", bus.countdown, v);
  endtask

  task automatic do_load(input logic [15:0] s);
    bus.seed = s;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    model_load(s);
  endtask

  initial begin
    int n;
    int cd_exp;
    logic [2:0] script [5] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100};
    logic [6:0] held;

    // ---- 1: reset values, 9-clk rounds, bullet saturation
    reset = 1'b1;
    bus.mode = 2'b11; bus.load = 1'b0; bus.seed = 16'h0000; bus.p1_choice = 3'b100;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    model_load(16'h0000);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      cd_exp = 127 >> i;
      chk($sformatf("t1:countdown_%0d", i), bus.countdown, cd_exp);
    end
    @(negedge clk);
    chk("t1:resolve_no_valid", bus.round_valid, 0);
    @(negedge clk);
    chk("t1:first_valid", bus.round_valid, 1);
    chk("t1:countdown_reload", bus.countdown, 7'h7F);
    model_round(3'b100);
    compare_all("t1r1");
    chk("t1:p1_bul_1", bus.p1_bullets, 1);
    play_round(3'b100, 1'b1, "t1r2");
    chk("t1:p1_bul_2", bus.p1_bullets, 2);
    play_round(3'b100, 1'b1, "t1r3");
    chk("t1:p1_bul_3", bus.p1_bullets, 3);
    play_round(3'b100, 1'b1, "t1r4");
    chk("t1:p1_bul_sat", bus.p1_bullets, 3);

    // ---- 2: empty shoot and non-one-hot choice resolve to idle
    do_load(16'h1234);
    play_round(3'b010, 1'b1, "t2a");
    chk("t2:empty_shoot_act", bus.p1_act, 0);
    chk("t2:empty_shoot_bul", bus.p1_bullets, 0);
    play_round(3'b011, 1'b1, "t2b");
    chk("t2:two_hot_act", bus.p1_act, 0);
    play_round(3'b100, 1'b1, "t2c");
    play_round(3'b110, 1'b1, "t2d");
    chk("t2:two_hot_loaded_act", bus.p1_act, 0);

    // ---- 4: pause mid-countdown freezes everything
    do_load(16'hBEEF);
    bus.p1_choice = 3'b100;
    wait_countdown(7'h0F);
    bus.mode = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t4:frozen_countdown", bus.countdown, 7'h0F);
      chk("t4:frozen_valid", bus.round_valid, 0);
    end
    bus.mode = 2'b11;
    @(negedge clk);
    chk("t4:resume", bus.countdown, 7'h07);
    wait_round(n);
    model_round(3'b100);
    compare_all("t4r1");
    play_round(3'b010, 1'b1, "t4r2");

    // ---- 5: normal/demo tick rates and mode-change counter clear
    do_load(16'h5A5A);
    bus.p1_choice = 3'b001;
    bus.mode = 2'b01;
    steps_until_change(n);
    steps_until_change(n);
    chk("t5:normal_interval", n, 6);
    bus.mode = 2'b10;
    steps_until_change(n);
    steps_until_change(n);
    chk("t5:demo_interval", n, 4);
    chk("t5:cd_after_demo", bus.countdown, 7'h07);
    repeat (2) @(negedge clk);
    chk("t5:mid_step_hold", bus.countdown, 7'h07);
    bus.mode = 2'b11;
    @(negedge clk);
    chk("t5:sim_next_clk", bus.countdown, 7'h03);
    wait_round(n);
    model_round(3'b001);
    compare_all("t5r1");

    // ---- 3: scripted then random match from seed 1 until a winner
    do_load(16'h0001);
    for (int r = 0; r < 200 && !m_done; r++) begin
      if (r < 10) play_round(script[r % 5], 1'b1, $sformatf("t3r%0d", r));
      else        play_round(3'($urandom_range(0, 7)), 1'b1, $sformatf("t3r%0d", r));
    end

    // ---- 6: DONE holds, load with seed 0 restarts, reset mid-RESOLVE
    if (m_done) begin
      held = bus.countdown;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("t6:done_no_valid", bus.round_valid, 0);
        chk("t6:done_match_over", bus.match_over, 1);
      end
      chk("t6:done_countdown_hold", bus.countdown, held);
    end
    do_load(16'h0000);
    check_reset_vals("t6:after_load");
    play_round(3'b100, 1'b1, "t6r1");
    play_round(3'b010, 1'b1, "t6r2");
    wait_countdown(7'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("t6:reset_in_resolve");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6:reset_no_valid", bus.round_valid, 0);
    end
    reset = 1'b0;
    model_load(16'h0000);
    play_round(3'b001, 1'b1, "t6r3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/standoff_match_engine.md
Name: standoff_match_engine

Overview:
- Parametrised successor of the standoff game core.
- Runs a best-of match between player 1 (one-hot choice input) and a pseudo-random player 2 (LFSR).
- Has a configurable bullet capacity, countdown length and round-interval tick rates.
- Keeps per-player scores with a match-over detect, and feeds the LED/seven-segment display logic above it.

Parameters:
- MAX_BULLETS, 3: bullet saturation value per player.
- BW, 2: bullet counter width; must hold MAX_BULLETS.
- COUNT_STEPS, 7: countdown LED width (thermometer).
- TICK_NORMAL, 50_000_000: clocks per countdown step in normal mode.
- TICK_DEMO, 10_000_000: clocks per countdown step in demo mode.
- WIN_SCORE, 3: points needed to win the match.
- SW, 3: score counter width; must hold WIN_SCORE.

Ports:
- clk, input, 1: system clock (100 MHz).
- reset, input, 1: asynchronous, active-high reset.
- mode, input, 2: round interval. 00 = pause, 01 = normal, 10 = demo, 11 = simulation (1 clk/step).
- load, input, 1: synchronous. Loads seed into the LFSR and restarts the match.
- seed, input, 16: LFSR seed.
- p1_choice, input, 3: 100 = reload, 010 = shoot, 001 = shield.
- p1_bullets, output, BW: player 1 bullet count.
- p2_bullets, output, BW: player 2 bullet count.
- p1_act, output, 3: last resolved one-hot action of player 1 (000 = idle).
- p2_act, output, 3: last resolved one-hot action of player 2.
- countdown, output, COUNT_STEPS: thermometer countdown LEDs.
- p1_score, output, SW: player 1 score.
- p2_score, output, SW: player 2 score.
- round_valid, output, 1: one-cycle pulse when round results update.
- match_over, output, 1: high while in DONE.
- winner, output, 2: 00 = none, 01 = player 1, 10 = player 2.

Behaviour:
- Reset (async): state = COUNT, countdown = all ones, bullets = 0, scores = 0, acts = 000, round_valid = 0, match_over = 0, winner = 00, tick counter = 0, LFSR = 16'hACE1.
- Tick generator: counts to TICK_NORMAL-1 (mode 01) or TICK_DEMO-1 (mode 10), then pulses tick. Mode 11 ticks every clk. Mode 00 freezes the tick counter, countdown and state; the LFSR also holds. Any mode change clears the tick counter.
- COUNT state, on tick:
  - countdown != 0: countdown <= countdown >> 1.
  - countdown == 0: go to RESOLVE.
- In mode 11 a round is exactly 9 clks from countdown = all ones to the round_valid pulse.
- RESOLVE (1 clk) samples p1_choice.
  - p1_choice not exactly one-hot → idle.
  - p1 shoot with 0 bullets → idle.
- p2 action from LFSR[1:0]: 00 or 11 = reload, 01 = shoot, 10 = shield. p2 shoot with 0 bullets → reload.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. Shifts once per RESOLVE only.
- Reload: bullets + 1, saturating at MAX_BULLETS.
- Shoot: bullets − 1.
- Scoring:
  - A player that shoots while the opponent reloads or is idle scores +1.
  - shoot vs shield: blocked, no point.
  - shoot vs shoot: both spend a bullet, no point.
- Results, next cycle after RESOLVE:
  - Bullets, acts and scores update, and round_valid = 1 for one clk.
  - If a score reaches WIN_SCORE, go to DONE; otherwise go to COUNT with countdown = all ones.
- DONE: match_over = 1, winner set. All counters hold and mode is ignored; exit only by load or reset.
- load (any state, priority over tick and RESOLVE):
  - LFSR <= seed, or 16'hACE1 if seed == 0.
  - Scores, bullets and acts cleared, winner = 00, state = COUNT, countdown = all ones, tick counter cleared.
- Reset has priority over load.
- Scores and bullets never wrap.

Test Plan:
1. Reset, mode = 11, p1_choice = 100 held → countdown 7F, 3F, …, 00. round_valid every 9 clks. p1_bullets 1, 2, 3, 3 (saturates at 3).
2. mode = 11, p1_choice = 010 with p1_bullets = 0 → p1_act = 000, p1_bullets stays 0. p1_choice = 011 → treated as idle.
3. load with seed = 16'h0001, then scripted p1 choices 100, 010, 001, 010, 100, … checked against a bench reference model of the LFSR and rules → bullets, acts and scores match every round_valid. match_over asserts when a score = 3, and winner is correct.
4. mode = 00 mid-countdown (countdown = 0F) for 50 clks → countdown, state and LFSR frozen. Return to 11 → countdown resumes from 0F.
5. mode = 10 with TICK_DEMO overridden to 4 → countdown steps every 4 clks. Switch to 11 mid-step → tick counter cleared, next step 1 clk later.
6. In DONE, pulse load with seed = 0 → LFSR = ACE1, scores 0, winner 00, countdown 7F. Assert reset mid-RESOLVE → all outputs at reset values, no round_valid.
